// File: rtl/rdmx_pkg.sv
// Shared constants, FSM encodings and helpers for the RDMX region
// configuration block.
package rdmx_pkg;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    localparam logic [5:0] REG_ID          = 6'd0;
    localparam logic [5:0] REG_COMMIT      = 6'd1;
    localparam logic [5:0] REG_SCRATCH     = 6'd2;
    localparam logic [5:0] REG_REGION_BASE = 6'd8;

    localparam logic [1:0] ADDR_H = 2'd0;
    localparam logic [1:0] ADDR_L = 2'd1;
    localparam logic [1:0] SIZE_H = 2'd2;
    localparam logic [1:0] SIZE_L = 2'd3;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic [31:0] apply_strb(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic is_region(
        input logic [5:0] idx,
        input int         n
    );
        return (int'(idx) >= int'(REG_REGION_BASE)) &&
               (int'(idx) <  int'(REG_REGION_BASE) + 4 * n);
    endfunction

endpackage

// File: rtl/rdmx_region_bank.sv
// One region: byte-strobed shadow registers, atomic commit to the
// active copy and a one-cycle update pulse.
module rdmx_region_bank
    import rdmx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  field,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        commit,
    output logic [63:0] shadow_addr,
    output logic [63:0] shadow_size,
    output logic [63:0] active_addr,
    output logic [63:0] active_size,
    output logic        update
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_addr <= '0;
            shadow_size <= '0;
            active_addr <= '0;
            active_size <= '0;
            update      <= 1'b0;
        end else begin
            update <= commit;
            // commit copies the shadow as it stood before this edge
            if (commit) begin
                active_addr <= shadow_addr;
                active_size <= shadow_size;
            end
            if (wr_en) begin
                unique case (field)
                    ADDR_H: shadow_addr[63:32] <=
                        apply_strb(shadow_addr[63:32], wdata, wstrb);
                    ADDR_L: shadow_addr[31:0] <=
                        apply_strb(shadow_addr[31:0], wdata, wstrb);
                    SIZE_H: shadow_size[63:32] <=
                        apply_strb(shadow_size[63:32], wdata, wstrb);
                    SIZE_L: shadow_size[31:0] <=
                        apply_strb(shadow_size[31:0], wdata, wstrb);
                endcase
            end
        end
    end

endmodule

// File: rtl/rdmx_region_ctl.sv
// AXI4-Lite slave with shadow/active region registers and atomic
// commit for the RDMX shims.
module rdmx_region_ctl
    import rdmx_pkg::*;
#(
    parameter int          NUM_REGIONS = 3,
    parameter logic [7:0]  ADDR_MASK   = 8'hFF,
    parameter logic [15:0] REV         = 16'h0001
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              S_AXI_AWADDR,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [2:0]               S_AXI_AWPROT,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [31:0]              S_AXI_ARADDR,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    input  logic [2:0]               S_AXI_ARPROT,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [64*NUM_REGIONS-1:0] REGION_ADDR,
    output logic [64*NUM_REGIONS-1:0] REGION_SIZE,
    output logic [NUM_REGIONS-1:0]   REGION_UPDATE
);

    logic        live;
    w_state_t    w_q, w_d;
    r_state_t    r_q, r_d;
    logic        wr_hs, rd_hs;
    logic [7:0]  aw_m, ar_m;
    logic [5:0]  w_idx, r_idx;
    logic [3:0]  w_reg, r_reg;
    logic [1:0]  w_fld, r_fld;
    logic [1:0]  w_resp, bresp_q;
    logic [31:0] rd_data, rdata_q;
    logic [1:0]  rd_resp, rresp_q;
    logic [31:0] scratch;
    logic [31:0] cmask;
    logic [63:0] sel_addr, sel_size;
    logic [63:0] sh_addr [NUM_REGIONS];
    logic [63:0] sh_size [NUM_REGIONS];
    logic        unused_bits;

    assign aw_m  = S_AXI_AWADDR[7:0] & ADDR_MASK;
    assign ar_m  = S_AXI_ARADDR[7:0] & ADDR_MASK;
    assign w_idx = aw_m[7:2];
    assign r_idx = ar_m[7:2];
    assign w_reg = w_idx[5:2] - 4'd2;
    assign r_reg = r_idx[5:2] - 4'd2;
    assign w_fld = w_idx[1:0];
    assign r_fld = r_idx[1:0];
    assign cmask = apply_strb(32'h0, S_AXI_WDATA, S_AXI_WSTRB);

    assign unused_bits = ^{S_AXI_AWADDR[31:8], S_AXI_ARADDR[31:8],
                           aw_m[1:0], ar_m[1:0], S_AXI_AWPROT,
                           S_AXI_ARPROT, cmask};

    // held low through reset; opens the slave one edge after release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) live <= 1'b0;
        else       live <= 1'b1;
    end

    always_comb begin
        w_d           = w_q;
        wr_hs         = 1'b0;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        unique case (w_q)
            W_IDLE: begin
                wr_hs         = live & S_AXI_AWVALID & S_AXI_WVALID;
                S_AXI_AWREADY = wr_hs;
                S_AXI_WREADY  = wr_hs;
                if (wr_hs) w_d = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_d = W_IDLE;
            end
        endcase
    end

    always_comb begin
        w_resp = OKAY;
        unique case (1'b1)
            (w_idx == REG_ID):            w_resp = SLVERR;
            (w_idx == REG_COMMIT),
            (w_idx == REG_SCRATCH),
            is_region(w_idx, NUM_REGIONS): w_resp = OKAY;
            default:                      w_resp = DECERR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q     <= W_IDLE;
            bresp_q <= OKAY;
            scratch <= '0;
        end else begin
            w_q <= w_d;
            if (wr_hs) begin
                bresp_q <= w_resp;
                if (w_idx == REG_SCRATCH)
                    scratch <= apply_strb(scratch, S_AXI_WDATA, S_AXI_WSTRB);
            end
        end
    end

    assign S_AXI_BRESP = bresp_q;

    for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_bank
        logic we, cm;
        assign we = wr_hs && is_region(w_idx, NUM_REGIONS) &&
                    (w_reg == 4'(r));
        assign cm = wr_hs && (w_idx == REG_COMMIT) && cmask[r];

        rdmx_region_bank u_bank (
            .clk         (clk),
            .reset       (reset),
            .wr_en       (we),
            .field       (w_fld),
            .wdata       (S_AXI_WDATA),
            .wstrb       (S_AXI_WSTRB),
            .commit      (cm),
            .shadow_addr (sh_addr[r]),
            .shadow_size (sh_size[r]),
            .active_addr (REGION_ADDR[64*r +: 64]),
            .active_size (REGION_SIZE[64*r +: 64]),
            .update      (REGION_UPDATE[r])
        );
    end

    always_comb begin
        r_d           = r_q;
        rd_hs         = 1'b0;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        unique case (r_q)
            R_IDLE: begin
                S_AXI_ARREADY = live;
                rd_hs         = live & S_AXI_ARVALID;
                if (rd_hs) r_d = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) r_d = R_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_data  = '0;
        rd_resp  = OKAY;
        sel_addr = '0;
        sel_size = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (r_reg == 4'(r)) begin
                sel_addr = sh_addr[r];
                sel_size = sh_size[r];
            end
        end
        unique case (1'b1)
            (r_idx == REG_ID):
                rd_data = {REV, 8'h00, 8'(NUM_REGIONS)};
            (r_idx == REG_COMMIT):
                rd_data = '0;
            (r_idx == REG_SCRATCH):
                rd_data = scratch;
            is_region(r_idx, NUM_REGIONS): begin
                unique case (r_fld)
                    ADDR_H: rd_data = sel_addr[63:32];
                    ADDR_L: rd_data = sel_addr[31:0];
                    SIZE_H: rd_data = sel_size[63:32];
                    SIZE_L: rd_data = sel_size[31:0];
                endcase
            end
            default: begin
                rd_data = '0;
                rd_resp = DECERR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q     <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= OKAY;
        end else begin
            r_q <= r_d;
            if (rd_hs) begin
                rdata_q <= rd_data;
                rresp_q <= rd_resp;
            end
        end
    end

    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;

endmodule

// File: tb/tb_rdmx_region_ctl.sv
// Directed bench for rdmx_region_ctl: register map, strobes, commit
// pulses, error responses, reset behaviour and read/write collision.
module tb_rdmx_region_ctl;
    import rdmx_pkg::*;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [31:0]    awaddr, wdata, araddr;
    logic [3:0]     wstrb;
    logic           awvalid, wvalid, bready, arvalid, rready;
    logic           awready, wready, bvalid, arready, rvalid;
    logic [1:0]     bresp, rresp;
    logic [31:0]    rdata;
    logic [64*N-1:0] region_addr, region_size;
    logic [N-1:0]   region_update;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0] d;
    logic [1:0]  resp;

    always #5 clk = ~clk;

    rdmx_region_ctl #(
        .NUM_REGIONS (N),
        .ADDR_MASK   (8'hFF),
        .REV         (16'h0001)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .REGION_ADDR   (region_addr),
        .REGION_SIZE   (region_size),
        .REGION_UPDATE (region_update)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_issue(input logic [5:0] idx, input logic [31:0] dv,
                            input logic [3:0] sv);
        bit ok = 1'b0;
        @(negedge clk);
        awaddr  = {24'h0, idx, 2'b00};
        wdata   = dv;
        wstrb   = sv;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (awready && wready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!ok) begin
            err_cnt++;
            $error("FAIL wr_issue idx=%0d observed=no_handshake expected=handshake", idx);
        end
    endtask

    task automatic wr_resp(output logic [1:0] rs);
        bit ok = 1'b0;
        rs = 2'bxx;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bvalid) begin
                rs     = bresp;
                bready = 1'b1;
                @(posedge clk);
                #1;
                bready = 1'b0;
                ok     = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            err_cnt++;
            $error("FAIL wr_resp observed=no_bvalid expected=bvalid");
        end
    endtask

    task automatic wr(input logic [5:0] idx, input logic [31:0] dv,
                      input logic [3:0] sv, output logic [1:0] rs);
        wr_issue(idx, dv, sv);
        wr_resp(rs);
    endtask

    task automatic rd_issue(input logic [5:0] idx);
        bit ok = 1'b0;
        @(negedge clk);
        araddr  = {24'h0, idx, 2'b00};
        arvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (arready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        arvalid = 1'b0;
        if (!ok) begin
            err_cnt++;
            $error("FAIL rd_issue idx=%0d observed=no_handshake expected=handshake", idx);
        end
    endtask

    task automatic rd_resp(output logic [31:0] dv, output logic [1:0] rs);
        bit ok = 1'b0;
        dv = 'x;
        rs = 2'bxx;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rvalid) begin
                dv     = rdata;
                rs     = rresp;
                rready = 1'b1;
                @(posedge clk);
                #1;
                rready = 1'b0;
                ok     = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            err_cnt++;
            $error("FAIL rd_resp observed=no_rvalid expected=rvalid");
        end
    endtask

    task automatic rd(input logic [5:0] idx, output logic [31:0] dv,
                      output logic [1:0] rs);
        rd_issue(idx);
        rd_resp(dv, rs);
    endtask

    initial begin
        reset   = 1'b1;
        awaddr  = '0;
        wdata   = '0;
        wstrb   = '0;
        araddr  = '0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        awvalid = 1'b1;
        wvalid  = 1'b1;
        #1;
        chk("rst_awready", 64'(awready), 64'h0);
        chk("rst_arready", 64'(arready), 64'h0);
        chk("rst_bvalid", 64'(bvalid), 64'h0);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_update", 64'(region_update), 64'h0);
        chk("rst_addr_or", 64'(|region_addr), 64'h0);
        chk("rst_size_or", 64'(|region_size), 64'h0);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("arready_after_rst", 64'(arready), 64'h1);

        rd(6'd0, d, resp);
        chk("id_data", 64'(d), 64'h0001_0003);
        chk("id_resp", 64'(resp), 64'(OKAY));

        wr(6'd12, 32'h0000_0012, 4'hF, resp);
        chk("r1_addrh_resp", 64'(resp), 64'(OKAY));
        wr(6'd13, 32'h3456_7800, 4'hF, resp);
        chk("r1_shadow_hidden", region_addr[127:64], 64'h0);

        wr_issue(6'd1, 32'h2, 4'hF);
        chk("r1_active", region_addr[127:64], 64'h12_3456_7800);
        chk("r1_pulse", 64'(region_update), 64'h2);
        chk("r0_untouched", region_addr[63:0], 64'h0);
        @(posedge clk);
        #1;
        chk("r1_pulse_end", 64'(region_update), 64'h0);
        wr_resp(resp);
        chk("commit_resp", 64'(resp), 64'(OKAY));

        wr(6'd11, 32'hFFFF_FFFF, 4'hF, resp);
        wr(6'd11, 32'h0000_00AB, 4'b0001, resp);
        rd(6'd11, d, resp);
        chk("strb_readback", 64'(d), 64'hFFFF_FFAB);

        wr(6'd11, 32'h1234_5678, 4'b0000, resp);
        chk("strb0_resp", 64'(resp), 64'(OKAY));
        rd(6'd11, d, resp);
        chk("strb0_nochange", 64'(d), 64'hFFFF_FFAB);

        wr_issue(6'd1, 32'h0, 4'hF);
        chk("commit0_pulse", 64'(region_update), 64'h0);
        wr_resp(resp);
        chk("commit0_resp", 64'(resp), 64'(OKAY));

        wr_issue(6'd1, 32'hFFFF_FFF8, 4'hF);
        chk("commit_hibits_pulse", 64'(region_update), 64'h0);
        wr_resp(resp);

        wr_issue(6'd1, 32'h1, 4'hF);
        chk("r0_size_active", region_size[63:0], 64'hFFFF_FFAB);
        chk("r0_pulse", 64'(region_update), 64'h1);
        wr_resp(resp);

        wr(6'd13, 32'hAAAA_0000, 4'hF, resp);
        chk("shadow_not_active", region_addr[127:64], 64'h12_3456_7800);
        rd(6'd13, d, resp);
        chk("shadow_readback", 64'(d), 64'hAAAA_0000);

        rd(6'd1, d, resp);
        chk("commit_reads0", 64'(d), 64'h0);

        wr_issue(6'd0, 32'hFFFF_FFFF, 4'hF);
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_bvalid", 64'(bvalid), 64'h1);
            chk("hold_awready", 64'(awready), 64'h0);
            chk("hold_bresp", 64'(bresp), 64'(SLVERR));
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wr_resp(resp);
        chk("id_wr_resp", 64'(resp), 64'(SLVERR));
        rd(6'd0, d, resp);
        chk("id_unchanged", 64'(d), 64'h0001_0003);

        wr(6'd5, 32'h5555_5555, 4'hF, resp);
        chk("dec_wr_resp", 64'(resp), 64'(DECERR));
        rd(6'd5, d, resp);
        chk("dec_rd_data", 64'(d), 64'h0);
        chk("dec_rd_resp", 64'(resp), 64'(DECERR));
        rd(6'd20, d, resp);
        chk("dec_past_regions", 64'(resp), 64'(DECERR));

        wr(6'd2, 32'hDEAD_BEEF, 4'hF, resp);
        rd_issue(6'd2);
        @(negedge clk);
        chk("pre_rst_rvalid", 64'(rvalid), 64'h1);
        reset = 1'b1;
        #1;
        chk("rst_mid_rvalid", 64'(rvalid), 64'h0);
        chk("rst_mid_arready", 64'(arready), 64'h0);
        chk("rst_mid_addr", 64'(|region_addr), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        rd(6'd2, d, resp);
        chk("scratch_after_rst", 64'(d), 64'h0);

        wr(6'd2, 32'h1111_1111, 4'hF, resp);
        @(negedge clk);
        araddr  = 32'h8;
        arvalid = 1'b1;
        awaddr  = 32'h8;
        wdata   = 32'h2222_2222;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        #1;
        chk("coll_arready", 64'(arready), 64'h1);
        chk("coll_awready", 64'(awready), 64'h1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        rd_resp(d, resp);
        chk("coll_old_data", 64'(d), 64'h1111_1111);
        wr_resp(resp);
        chk("coll_wr_resp", 64'(resp), 64'(OKAY));
        rd(6'd2, d, resp);
        chk("coll_new_data", 64'(d), 64'h2222_2222);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
